// File: rtl/stopwatch_input_controller.sv
// -----------------------------------------------------------------------------
// stopwatch_input_controller
//
// Front end for the decimal timer. It takes the raw active-low push buttons,
// synchronises and debounces them, and turns a debounced key press into a
// single-cycle event. A small IDLE/RUNNING/PAUSED state machine then drives
// the rate-divider pause input and a stretched active-low clear pulse.
//
// Optional build macro: LAP_HOLD_EN
//   When defined, adds the nLapKey input. A lap press while RUNNING toggles
//   holdDisplay. When undefined, there is no nLapKey port and holdDisplay is
//   tied to 0.
//
// Ports:
//   clock          in   system clock (CLOCK_50)
//   nReset         in   asynchronous active-low reset
//   nStartStopKey  in   raw start/stop key, active-low, asynchronous
//   nClearKey      in   raw clear key, active-low, asynchronous
//   nLapKey        in   raw lap key, active-low (LAP_HOLD_EN builds only)
//   pause          out  1 = timer halted, 0 = timer counting
//   nClearOut      out  active-low clear to rate dividers and counters
//   runState       out  00 IDLE, 01 RUNNING, 10 PAUSED
//   holdDisplay    out  display freeze flag (0 unless LAP_HOLD_EN)
// -----------------------------------------------------------------------------
module stopwatch_input_controller #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_WIDTH       = 20,
  parameter int CLEAR_CYCLES    = 4
) (
  input  logic       clock,
  input  logic       nReset,
  input  logic       nStartStopKey,
  input  logic       nClearKey,
`ifdef LAP_HOLD_EN
  input  logic       nLapKey,
`endif
  output logic       pause,
  output logic       nClearOut,
  output logic [1:0] runState,
  output logic       holdDisplay
);

  // ---------------------------------------------------------------------------
  // Key bundle: bit 0 start/stop, bit 1 clear, bit 2 lap (optional)
  // ---------------------------------------------------------------------------
  localparam int KEY_SS  = 0;
  localparam int KEY_CLR = 1;

`ifdef LAP_HOLD_EN
  localparam int KEY_LAP  = 2;
  localparam int NUM_KEYS = 3;
  logic [NUM_KEYS-1:0] keys_raw;
  assign keys_raw = {nLapKey, nClearKey, nStartStopKey};
`else
  localparam int NUM_KEYS = 2;
  logic [NUM_KEYS-1:0] keys_raw;
  assign keys_raw = {nClearKey, nStartStopKey};
`endif

  localparam logic [CNT_WIDTH-1:0] DEB_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]           CLR_LOAD = 4'(CLEAR_CYCLES);

  logic [NUM_KEYS-1:0] press_evt;

  // ---------------------------------------------------------------------------
  // Per-key synchroniser, debouncer and press-event generator
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      logic                 sync1_q;
      logic                 sync2_q;
      logic                 level_q;
      logic                 level_d;
      logic [CNT_WIDTH-1:0] cnt_q;
      logic [CNT_WIDTH-1:0] cnt_d;
      logic                 evt_q;
      logic                 evt_d;

      // The counter measures how long the synced level has disagreed with the
      // accepted level; any agreement restarts it, so only an uninterrupted
      // run of DEBOUNCE_CYCLES disagreeing cycles flips the accepted level.
      always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
          if (cnt_q == DEB_LAST) begin
            level_d = sync2_q;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
        // Only the released->pressed edge of the accepted level is an event.
        evt_d = level_q & ~level_d;
      end

      always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
          sync1_q <= 1'b1;
          sync2_q <= 1'b1;
          level_q <= 1'b1;
          cnt_q   <= '0;
          evt_q   <= 1'b0;
        end else begin
          sync1_q <= keys_raw[gi];
          sync2_q <= sync1_q;
          level_q <= level_d;
          cnt_q   <= cnt_d;
          evt_q   <= evt_d;
        end
      end

      assign press_evt[gi] = evt_q;
    end
  endgenerate

  logic ss_evt;
  logic clr_evt;
  assign ss_evt  = press_evt[KEY_SS];
  assign clr_evt = press_evt[KEY_CLR];

  // ---------------------------------------------------------------------------
  // Clear pulse stretcher
  // ---------------------------------------------------------------------------
  logic [3:0] clr_cnt_q;
  logic [3:0] clr_cnt_d;
  logic       nclr_q;
  logic       nclr_d;

  // The counter holds the number of low cycles still owed, including the
  // current one; a new clear event simply reloads it.
  always_comb begin
    if (clr_evt) begin
      clr_cnt_d = CLR_LOAD;
      nclr_d    = 1'b0;
    end else if (clr_cnt_q > 4'd1) begin
      clr_cnt_d = clr_cnt_q - 4'd1;
      nclr_d    = 1'b0;
    end else begin
      clr_cnt_d = 4'd0;
      nclr_d    = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      clr_cnt_q <= 4'd0;
      nclr_q    <= 1'b0;
    end else begin
      clr_cnt_q <= clr_cnt_d;
      nclr_q    <= nclr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Run-state machine
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUNNING = 2'b01,
    ST_PAUSED  = 2'b10
  } state_e;

  state_e state_q;
  state_e state_d;
  logic   pause_q;
  logic   pause_d;

  // State register (pause is registered alongside the state)
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= ST_IDLE;
      pause_q <= 1'b1;
    end else begin
      state_q <= state_d;
      pause_q <= pause_d;
    end
  end

  // Next state: clear has priority; start/stop is ignored while the clear
  // pulse is still being driven so the timer cannot start mid-clear.
  always_comb begin
    state_d = state_q;
    if (clr_evt) begin
      state_d = ST_IDLE;
    end else if (ss_evt && nclr_q) begin
      case (state_q)
        ST_IDLE:    state_d = ST_RUNNING;
        ST_RUNNING: state_d = ST_PAUSED;
        ST_PAUSED:  state_d = ST_RUNNING;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // Output decode, taken from the next state so it lands with the state flop
  always_comb begin
    pause_d = (state_d != ST_RUNNING);
  end

  // ---------------------------------------------------------------------------
  // Lap hold
  // ---------------------------------------------------------------------------
`ifdef LAP_HOLD_EN
  logic lap_evt;
  logic hold_q;
  logic hold_d;

  assign lap_evt = press_evt[KEY_LAP];

  always_comb begin
    hold_d = hold_q;
    if (clr_evt) begin
      hold_d = 1'b0;
    end else if (lap_evt && (state_q == ST_RUNNING)) begin
      hold_d = ~hold_q;
    end
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      hold_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
    end
  end

  assign holdDisplay = hold_q;
`else
  assign holdDisplay = 1'b0;
`endif

  assign pause     = pause_q;
  assign nClearOut = nclr_q;
  assign runState  = state_q;

endmodule

// File: tb/tb_stopwatch_input_controller.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_input_controller
//
// Scoreboard bench. The stimulus process drives the keys on the falling edge,
// advances a behavioural model by one clock and queues the outputs expected
// after the next rising edge. A separate monitor pops one entry per cycle and
// compares. The model describes debouncing as "the last DEBOUNCE_CYCLES
// synchronised samples all disagree with the accepted level" and tracks the
// run state and clear pulse as plain integers.
// -----------------------------------------------------------------------------
module tb_stopwatch_input_controller;

  localparam int DEB = 4;
  localparam int CLR = 4;
`ifdef LAP_HOLD_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       nReset;
  logic       nStartStopKey;
  logic       nClearKey;
`ifdef LAP_HOLD_EN
  logic       nLapKey;
`endif
  logic       pause;
  logic       nClearOut;
  logic [1:0] runState;
  logic       holdDisplay;

  always #5 clock = ~clock;

  stopwatch_input_controller #(
    .DEBOUNCE_CYCLES (DEB),
    .CNT_WIDTH       (3),
    .CLEAR_CYCLES    (CLR)
  ) dut (
    .clock         (clock),
    .nReset        (nReset),
    .nStartStopKey (nStartStopKey),
    .nClearKey     (nClearKey),
`ifdef LAP_HOLD_EN
    .nLapKey       (nLapKey),
`endif
    .pause         (pause),
    .nClearOut     (nClearOut),
    .runState      (runState),
    .holdDisplay   (holdDisplay)
  );

  typedef struct packed {
    logic       pause;
    logic       nclr;
    logic [1:0] rs;
    logic       hold;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   stim_done = 1'b0;

  // ---------------------------------------------------------------------------
  // Reference model (key index: 0 start/stop, 1 clear, 2 lap)
  // ---------------------------------------------------------------------------
  bit m_pipe [3][$];   // raw samples still travelling through the synchroniser
  bit m_win  [3][$];   // most recent synchronised samples, at most DEB long
  bit m_lvl  [3];      // accepted key level
  bit m_evt  [3];      // press accepted on the previous clock
  int m_st;            // 0 idle, 1 running, 2 paused
  int m_low;           // clear-low cycles remaining
  bit m_nclr;
  bit m_hold;

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_pipe[k].delete();
      m_pipe[k].push_back(1'b1);
      m_pipe[k].push_back(1'b1);
      m_win[k].delete();
      m_lvl[k] = 1'b1;
      m_evt[k] = 1'b0;
    end
    m_st   = 0;
    m_low  = 0;
    m_nclr = 1'b0;
    m_hold = 1'b0;
  endtask

  task automatic model_edge(input bit ss, input bit clr, input bit lap);
    bit raw [3];
    bit nev [3];
    bit s;
    bit dummy;
    bit all_diff;
    bit old_nclr;
    raw[0] = ss;
    raw[1] = clr;
    raw[2] = lap;
    for (int k = 0; k < 3; k++) begin
      m_pipe[k].push_back(raw[k]);
      s = m_pipe[k].pop_front();
      m_win[k].push_back(s);
      if (m_win[k].size() > DEB) dummy = m_win[k].pop_front();
      all_diff = (m_win[k].size() == DEB);
      for (int j = 0; j < m_win[k].size(); j++)
        if (m_win[k][j] == m_lvl[k]) all_diff = 1'b0;
      nev[k] = all_diff && m_lvl[k];
      if (all_diff) m_lvl[k] = ~m_lvl[k];
    end
    old_nclr = m_nclr;
    if (m_evt[1]) begin
      m_st   = 0;
      m_low  = CLR;
      m_hold = 1'b0;
    end else begin
      if (m_evt[2] && m_st == 1) m_hold = ~m_hold;
      if (m_evt[0] && old_nclr) m_st = (m_st == 1) ? 2 : 1;
      if (m_low > 0) m_low = m_low - 1;
    end
    m_nclr = (m_low == 0);
    for (int k = 0; k < 3; k++) m_evt[k] = nev[k];
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic cycle(input bit ss, input bit clr, input bit lap, input bit rst_n);
    exp_t e;
    bit   lap_drv;
    @(negedge clock);
    lap_drv = lap | ~LAP_EN;
`ifdef LAP_HOLD_EN
    nLapKey = lap_drv;
`endif
    nReset        = rst_n;
    nStartStopKey = ss;
    nClearKey     = clr;
    if (!rst_n) model_reset();
    else        model_edge(ss, clr, lap_drv);
    e.pause = (m_st != 1);
    e.nclr  = m_nclr;
    e.rs    = 2'(m_st);
    e.hold  = m_hold;
    exp_q.push_back(e);
  endtask

  task automatic drive(input bit ss, input bit clr, input bit lap, input bit rst_n, input int n);
    repeat (n) cycle(ss, clr, lap, rst_n);
  endtask

  // Directed spot check against constants, taken just after the next edge
  task automatic peek(input string name, input logic [1:0] rs, input logic p, input logic nc);
    @(posedge clock);
    #2;
    checks++;
    if (runState !== rs || pause !== p || nClearOut !== nc) begin
      errors++;
      $display("FAIL %s: runState=%b pause=%b nClearOut=%b, expected runState=%b pause=%b nClearOut=%b",
               name, runState, pause, nClearOut, rs, p, nc);
    end else begin
      $display("ok   %s: runState=%b pause=%b nClearOut=%b", name, runState, pause, nClearOut);
    end
  endtask

`ifdef LAP_HOLD_EN
  task automatic peek_hold(input string name, input logic h);
    @(posedge clock);
    #2;
    checks++;
    if (holdDisplay !== h) begin
      errors++;
      $display("FAIL %s: holdDisplay=%b, expected %b", name, holdDisplay, h);
    end else begin
      $display("ok   %s: holdDisplay=%b", name, holdDisplay);
    end
  endtask
`endif

  task automatic press_ss();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 6);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 8);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    bit lv  [3];
    int run [3];
    nReset        = 1'b0;
    nStartStopKey = 1'b1;
    nClearKey     = 1'b1;
`ifdef LAP_HOLD_EN
    nLapKey       = 1'b1;
`endif
    model_reset();

    // Reset state
    drive(1'b1, 1'b1, 1'b1, 1'b0, 3);
    peek("reset", 2'b00, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 2);

    // Held start/stop: state changes on the 7th edge, then nothing more
    drive(1'b0, 1'b1, 1'b1, 1'b1, 6);
    peek("latency edge6", 2'b00, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1);
    peek("latency edge7", 2'b01, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 3);
    peek("held key", 2'b01, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 10);

    // Short glitches from IDLE never qualify
    drive(1'b1, 1'b1, 1'b1, 1'b0, 2);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 2);
    repeat (3) begin
      drive(1'b0, 1'b1, 1'b1, 1'b1, 3);
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b1, 8);
    peek("glitches", 2'b00, 1'b1, 1'b1);

    // Three clean presses
    press_ss();
    peek("press1", 2'b01, 1'b0, 1'b1);
    press_ss();
    peek("press2", 2'b10, 1'b1, 1'b1);
    press_ss();
    peek("press3", 2'b01, 1'b0, 1'b1);

`ifdef LAP_HOLD_EN
    drive(1'b1, 1'b1, 1'b0, 1'b1, 6);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 8);
    peek_hold("lap1 running", 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 6);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 8);
    peek_hold("lap2 running", 1'b0);
    press_ss();
    peek("lap to paused", 2'b10, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 6);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 8);
    peek_hold("lap paused", 1'b0);
    press_ss();
    peek("lap back running", 2'b01, 1'b0, 1'b1);
`endif

    // Clear from RUNNING: nClearOut low after edges 7..10
    drive(1'b1, 1'b0, 1'b1, 1'b1, 6);
    peek("clear edge6", 2'b01, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1);
    peek("clear edge7", 2'b00, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 3);
    peek("clear edge10", 2'b00, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1);
    peek("clear edge11", 2'b00, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 6);

    // Simultaneous start/stop and clear: clear wins
    press_ss();
    peek("pre-simul", 2'b01, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 6);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1);
    peek("simul", 2'b00, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 9);

    // Start/stop landing inside the clear window is dropped
    drive(1'b1, 1'b0, 1'b1, 1'b1, 2);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 6);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 10);
    peek("ss in clear window", 2'b00, 1'b1, 1'b1);

    // Reset mid-debounce with key held: full re-qualification afterwards
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 2);
    peek("mid-debounce reset", 2'b00, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 6);
    peek("requalify edge6", 2'b00, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1);
    peek("requalify edge7", 2'b01, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 10);

    // Random key activity with occasional resets
    for (int k = 0; k < 3; k++) begin
      lv[k]  = 1'b1;
      run[k] = 0;
    end
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 3; k++) begin
        if (run[k] == 0) begin
          if (k == 1) lv[k] = ($urandom_range(0, 4) != 0);
          else        lv[k] = 1'($urandom_range(0, 1));
          run[k] = int'($urandom_range(1, 10));
        end
        run[k] = run[k] - 1;
      end
      if ($urandom_range(0, 399) == 0) begin
        drive(lv[0], lv[1], lv[2], 1'b0, 2);
      end else begin
        cycle(lv[0], lv[1], lv[2], 1'b1);
      end
    end
    drive(1'b1, 1'b1, 1'b1, 1'b1, 4);
    stim_done = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Monitor: one queued expectation per clock
  // ---------------------------------------------------------------------------
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({pause, nClearOut, runState, holdDisplay} !== e) begin
          errors++;
          $display("FAIL outputs @%0t: pause=%b nClearOut=%b runState=%b holdDisplay=%b, expected pause=%b nClearOut=%b runState=%b holdDisplay=%b",
                   $time, pause, nClearOut, runState, holdDisplay, e.pause, e.nclr, e.rs, e.hold);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // End of run
  // ---------------------------------------------------------------------------
  initial begin
    wait (stim_done);
    repeat (2) @(posedge clock);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
